// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
//   loader_state_t : top-level FSM states
//   BYTES_PER_WORD : stream bytes per 32-bit instruction word
//   LEN_BYTES      : bytes in the big-endian word-count header
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/loader_word_assembler.sv
// Assembles big-endian 32-bit words from a byte stream.
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : drop any partial word and restart at byte 0
//   shift_en      : byte_in is accepted this cycle
//   byte_in       : stream byte
//   word          : current three held bytes plus byte_in (valid with word_complete)
//   word_complete : this accepted byte is the last byte of a word
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [23:0] shift_reg;
    logic [1:0]  byte_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[15:0], byte_in};
            // wraps to 0 after the last byte, ready for the next word
            byte_cnt  <= byte_cnt + 2'd1;
        end
    end

    // The completing byte is folded in combinationally so the top can
    // register the full word on the same edge that accepts it.
    assign word          = {shift_reg, byte_in};
    assign word_complete = shift_en && (byte_cnt == LAST_BYTE);

endmodule

// File: rtl/program_loader.sv
// Program-memory writer: receives a length-prefixed, XOR-checksummed byte
// image and writes 32-bit words into program memory, holding the core in
// reset until the whole image has been verified.
//   clk, rst     : clock, asynchronous active-low reset
//   i_Start      : pulse, begins or restarts a load from any state
//   i_Byte, i_ByteValid, o_ByteReady : byte stream handshake
//   o_WrEn, o_WrAddr, o_WrData       : program-memory write port
//   o_CpuRst_n   : core reset, released only in DONE
//   o_Done       : image loaded and verified
//   o_Error      : length or checksum failure
//
// state  | meaning
// IDLE   | waiting for first start
// LEN_HI | expecting word-count high byte
// LEN_LO | expecting word-count low byte, then range check
// DATA   | receiving instruction words
// CHECK  | expecting checksum byte
// DONE   | image verified, core released
// ERROR  | bad length or checksum, core held
module program_loader
    import loader_pkg::*;
#(
    parameter  int MEMORY_DEPTH = 32,
    localparam int ADDR_W       = $clog2(MEMORY_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_Start,
    input  logic [7:0]        i_Byte,
    input  logic              i_ByteValid,
    output logic              o_ByteReady,
    output logic              o_WrEn,
    output logic [ADDR_W-1:0] o_WrAddr,
    output logic [31:0]       o_WrData,
    output logic              o_CpuRst_n,
    output logic              o_Done,
    output logic              o_Error
);

    localparam int              LEN_W     = 8 * LEN_BYTES;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(MEMORY_DEPTH);

    loader_state_t     state;
    logic [7:0]        checksum;
    logic [7:0]        len_hi;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   word_idx;
    logic [ADDR_W:0]   word_idx_next;
    logic [LEN_W-1:0]  len_val;
    logic              accept;
    logic              shift_en;
    logic [31:0]       word;
    logic              word_complete;

    assign accept        = i_ByteValid && o_ByteReady;
    assign len_val       = {len_hi, i_Byte};
    assign word_idx_next = word_idx + 1'b1;
    // a start pulse wins over a byte arriving in the same cycle
    assign shift_en      = accept && (state == DATA) && !i_Start;

    loader_word_assembler u_word_assembler (
        .clk           (clk),
        .rst           (rst),
        .clear         (i_Start),
        .shift_en      (shift_en),
        .byte_in       (i_Byte),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            o_ByteReady <= 1'b0;
            o_WrEn      <= 1'b0;
            o_WrAddr    <= '0;
            o_WrData    <= '0;
            o_CpuRst_n  <= 1'b0;
            o_Done      <= 1'b0;
            o_Error     <= 1'b0;
            checksum    <= '0;
            len_hi      <= '0;
            n_words     <= '0;
            word_idx    <= '0;
        end else begin
            o_WrEn <= 1'b0;
            if (i_Start) begin
                state       <= LEN_HI;
                o_ByteReady <= 1'b1;
                o_CpuRst_n  <= 1'b0;
                o_Done      <= 1'b0;
                o_Error     <= 1'b0;
                checksum    <= '0;
                len_hi      <= '0;
                n_words     <= '0;
                word_idx    <= '0;
            end else begin
                case (state)
                    LEN_HI: begin
                        if (accept) begin
                            len_hi   <= i_Byte;
                            checksum <= checksum ^ i_Byte;
                            state    <= LEN_LO;
                        end
                    end
                    LEN_LO: begin
                        if (accept) begin
                            checksum <= checksum ^ i_Byte;
                            if (len_val > DEPTH_LEN) begin
                                state       <= ERROR;
                                o_ByteReady <= 1'b0;
                                o_Error     <= 1'b1;
                            end else if (len_val == '0) begin
                                state <= CHECK;
                            end else begin
                                n_words <= len_val[ADDR_W:0];
                                state   <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            checksum <= checksum ^ i_Byte;
                            if (word_complete) begin
                                o_WrEn   <= 1'b1;
                                o_WrAddr <= word_idx[ADDR_W-1:0];
                                o_WrData <= word;
                                word_idx <= word_idx_next;
                                if (word_idx_next == n_words) begin
                                    state <= CHECK;
                                end
                            end
                        end
                    end
                    CHECK: begin
                        if (accept) begin
                            o_ByteReady <= 1'b0;
                            if (i_Byte == checksum) begin
                                state      <= DONE;
                                o_Done     <= 1'b1;
                                o_CpuRst_n <= 1'b1;
                            end else begin
                                state   <= ERROR;
                                o_Error <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int MEMORY_DEPTH = 32;
    localparam int ADDR_W       = $clog2(MEMORY_DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_Start = 1'b0;
    logic [7:0]        i_Byte = '0;
    logic              i_ByteValid = 1'b0;
    logic              o_ByteReady;
    logic              o_WrEn;
    logic [ADDR_W-1:0] o_WrAddr;
    logic [31:0]       o_WrData;
    logic              o_CpuRst_n;
    logic              o_Done;
    logic              o_Error;

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic              wren_prev = 1'b0;
    logic [7:0]        frm[$];

    program_loader #(.MEMORY_DEPTH(MEMORY_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_Start     (i_Start),
        .i_Byte      (i_Byte),
        .i_ByteValid (i_ByteValid),
        .o_ByteReady (o_ByteReady),
        .o_WrEn      (o_WrEn),
        .o_WrAddr    (o_WrAddr),
        .o_WrData    (o_WrData),
        .o_CpuRst_n  (o_CpuRst_n),
        .o_Done      (o_Done),
        .o_Error     (o_Error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write log sampled mid-cycle; also flags back-to-back strobes.
    always @(negedge clk) begin
        if (o_WrEn) begin
            check("wren_gap", {31'd0, wren_prev}, 32'd0);
            wr_addr_q.push_back(o_WrAddr);
            wr_data_q.push_back(o_WrData);
        end
        wren_prev <= o_WrEn;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit sent;
        int n;
        sent = 1'b0;
        n    = 0;
        i_Byte      = b;
        i_ByteValid = 1'b1;
        while (!sent && n < 50) begin
            sent = o_ByteReady;
            if (!sent) begin
                stalls++;
                n++;
            end
            tick();
        end
        if (!sent) check("byte_timeout", 32'd1, 32'd0);
        i_ByteValid = 1'b0;
    endtask

    task automatic send_frame(input bit gapped);
        foreach (frm[i]) begin
            send_byte(frm[i]);
            if (gapped) repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        stalls = 0;
    endtask

    task automatic load_frame1(input logic [7:0] chk);
        frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h20, 8'h09, 8'h00, 8'h0A, chk};
    endtask

    task automatic check_frame1_writes(input string tag);
        check({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check({tag, "_a0"}, 32'(wr_addr_q[0]), 32'd0);
            check({tag, "_d0"}, wr_data_q[0], 32'h20080005);
            check({tag, "_a1"}, 32'(wr_addr_q[1]), 32'd1);
            check({tag, "_d1"}, wr_data_q[1], 32'h2009000A);
        end
    endtask

    task automatic check_status(input string tag, input logic rdy, input logic done,
                                input logic err, input logic cpu);
        check({tag, "_ready"}, {31'd0, o_ByteReady}, {31'd0, rdy});
        check({tag, "_done"},  {31'd0, o_Done},      {31'd0, done});
        check({tag, "_error"}, {31'd0, o_Error},     {31'd0, err});
        check({tag, "_cpurst"}, {31'd0, o_CpuRst_n}, {31'd0, cpu});
    endtask

    task automatic check_reset_values(input string tag);
        check_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, "_wren"},  {31'd0, o_WrEn}, 32'd0);
        check({tag, "_waddr"}, 32'(o_WrAddr), 32'd0);
        check({tag, "_wdata"}, o_WrData, 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nwr;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst = 1'b1;
        tick();
        check_reset_values("idle");

        // 1: nominal back-to-back load
        clear_log();
        load_frame1(8'h0C);
        pulse_start();
        check("t1_ready_lenhi", {31'd0, o_ByteReady}, 32'd1);
        send_frame(1'b0);
        tick();
        check_frame1_writes("t1");
        check_status("t1", 1'b0, 1'b1, 1'b0, 1'b1);
        check("t1_stalls", 32'(stalls), 32'd0);

        // restart from DONE re-asserts core reset at once
        clear_log();
        pulse_start();
        check_status("t2_start", 1'b1, 1'b0, 1'b0, 1'b0);

        // 2: zero length
        frm = '{8'h00, 8'h00, 8'h00};
        send_frame(1'b0);
        tick();
        check("t2_nwr", 32'(wr_addr_q.size()), 32'd0);
        check_status("t2", 1'b0, 1'b1, 1'b0, 1'b1);

        // single word
        clear_log();
        frm = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
        pulse_start();
        send_frame(1'b0);
        tick();
        check("n1_nwr", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) check("n1_d0", wr_data_q[0], 32'hDEADBEEF);
        check_status("n1", 1'b0, 1'b1, 1'b0, 1'b1);

        // 3: overlength; error visible right after LEN_LO
        clear_log();
        frm = '{8'h00, 8'h21};
        pulse_start();
        send_frame(1'b0);
        check_status("t3", 1'b0, 1'b0, 1'b1, 1'b0);
        // bytes offered while not ready must be ignored
        i_Byte = 8'h55;
        i_ByteValid = 1'b1;
        repeat (4) tick();
        i_ByteValid = 1'b0;
        check_status("t3_hold", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_nwr", 32'(wr_addr_q.size()), 32'd0);

        // exactly MEMORY_DEPTH words is accepted
        clear_log();
        frm = '{8'h00, 8'h20};
        pulse_start();
        send_frame(1'b0);
        check_status("n32_hdr", 1'b1, 1'b0, 1'b0, 1'b0);

        // 4: bad checksum, then recovery
        clear_log();
        load_frame1(8'hFF);
        pulse_start();
        send_frame(1'b0);
        tick();
        check_frame1_writes("t4");
        check_status("t4", 1'b0, 1'b0, 1'b1, 1'b0);
        clear_log();
        load_frame1(8'h0C);
        pulse_start();
        send_frame(1'b0);
        tick();
        check_frame1_writes("t4r");
        check_status("t4r", 1'b0, 1'b1, 1'b0, 1'b1);

        // 5: gapped valid
        clear_log();
        load_frame1(8'h0C);
        pulse_start();
        send_frame(1'b1);
        tick();
        check_frame1_writes("t5");
        check_status("t5", 1'b0, 1'b1, 1'b0, 1'b1);

        // 6: async reset after 6 data bytes
        clear_log();
        load_frame1(8'h0C);
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(frm[i]);
        rst = 1'b0;
        #1;
        check_reset_values("t6_rst");
        nwr = wr_addr_q.size();
        check("t6_pre_nwr", 32'(nwr), 32'd1);
        tick();
        rst = 1'b1;
        repeat (5) tick();
        check("t6_post_nwr", 32'(wr_addr_q.size()), 32'(nwr));
        check_reset_values("t6_idle");
        clear_log();
        pulse_start();
        send_frame(1'b0);
        tick();
        check_frame1_writes("t6r");
        check_status("t6r", 1'b0, 1'b1, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
